// File: rtl/btn_pulse_conditioner.sv
// Debounces raw switch/key levels into clean levels plus one-cycle press/release pulses.
// A shared prescaler strobes the per-channel integrators at the debounce sample rate.
module btn_pulse_conditioner #(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned TICK_DIV   = 1250000,
    parameter int unsigned STABLE     = 2,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] LEVEL,
    output logic [WIDTH-1:0] PULSE_ON,
    output logic [WIDTH-1:0] PULSE_OFF,
    output logic             TICK
);

    localparam int unsigned      DivW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DivW-1:0]  DivMax    = DivW'(TICK_DIV - 1);
    localparam logic [3:0]       StableMax = 4'(STABLE - 1);
    localparam logic [WIDTH-1:0] IdleRaw   = {WIDTH{ACTIVE_LOW}};

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [DivW-1:0]  r_div;
    logic [3:0]       r_cnt [WIDTH];
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_pulse_on;
    logic [WIDTH-1:0] r_pulse_off;

    logic             w_tick;
    logic [WIDTH-1:0] w_sample;
    logic [WIDTH-1:0] w_level_d;
    logic [3:0]       w_cnt_d [WIDTH];
    logic [DivW-1:0]  w_div_d;

    // Sync flops reset to the inactive raw level so the normalised sample starts at 0.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= IdleRaw;
            r_sync2 <= IdleRaw;
        end else begin
            r_sync1 <= DIN;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2 ^ IdleRaw;
    assign w_tick   = (r_div == DivMax);
    assign w_div_d  = w_tick ? '0 : r_div + 1'b1;

    always_comb begin
        w_level_d = r_level;
        w_cnt_d   = r_cnt;
        if (w_tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sample[i] == r_level[i]) begin
                    w_cnt_d[i] = 4'd0;
                end else if (r_cnt[i] == StableMax) begin
                    w_level_d[i] = w_sample[i];
                    w_cnt_d[i]   = 4'd0;
                end else begin
                    w_cnt_d[i] = r_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_div       <= '0;
            r_level     <= '0;
            r_pulse_on  <= '0;
            r_pulse_off <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= 4'd0;
            end
        end else begin
            r_div       <= w_div_d;
            r_level     <= w_level_d;
            r_cnt       <= w_cnt_d;
            // Pulses register alongside the level so they coincide with its new value.
            r_pulse_on  <= w_level_d & ~r_level;
            r_pulse_off <= ~w_level_d & r_level;
        end
    end

    assign LEVEL     = r_level;
    assign PULSE_ON  = r_pulse_on;
    assign PULSE_OFF = r_pulse_off;
    assign TICK      = w_tick;

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Directed bench: reset, tick phase, clean press/release, bounce, simultaneous, mid-debounce
// reset and active-low polarity, all with TICK_DIV = 4 and STABLE = 3.
module tb_btn_pulse_conditioner;

    logic       clk;
    logic       rst_n;
    logic [2:0] din;
    logic [2:0] level, pulse_on, pulse_off;
    logic       tick;
    logic [2:0] din_al;
    logic [2:0] level_al, pulse_on_al, pulse_off_al;
    logic       tick_al;

    int n_vec = 0;
    int n_err = 0;

    btn_pulse_conditioner #(
        .WIDTH(3), .TICK_DIV(4), .STABLE(3), .ACTIVE_LOW(1'b0)
    ) u_dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .DIN      (din),
        .LEVEL    (level),
        .PULSE_ON (pulse_on),
        .PULSE_OFF(pulse_off),
        .TICK     (tick)
    );

    btn_pulse_conditioner #(
        .WIDTH(3), .TICK_DIV(4), .STABLE(3), .ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .DIN      (din_al),
        .LEVEL    (level_al),
        .PULSE_ON (pulse_on_al),
        .PULSE_OFF(pulse_off_al),
        .TICK     (tick_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to the negedge just after the next tick edge; bounded search.
    task automatic tick_step();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (tick === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $error("FAIL tick_timeout: observed no TICK expected TICK within 8 cycles");
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        din    = 3'b111;
        din_al = 3'b000;
        repeat (20) @(negedge clk);
        check("rst_level", level, 3'b000);
        check("rst_pon", pulse_on, 3'b000);
        check("rst_poff", pulse_off, 3'b000);
        check("rst_tick", {2'b00, tick}, 3'b000);

        // Release: TICK high only in cycles 4 and 8 (after edges 3 and 7).
        din    = 3'b000;
        din_al = 3'b111;
        rst_n  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("tick_phase_%0d", i), {2'b00, tick}, (i % 4 == 3) ? 3'b001 : 3'b000);
            check($sformatf("al_idle_pon_%0d", i), pulse_on_al, 3'b000);
        end
        check("al_idle_level", level_al, 3'b000);

        // Clean press on ch0, with active-low press on the second instance in parallel.
        din    = 3'b001;
        din_al = 3'b110;
        tick_step();
        check("press_t1_level", level, 3'b000);
        tick_step();
        check("press_t2_level", level, 3'b000);
        check("press_t2_pon", pulse_on, 3'b000);
        tick_step();
        check("press_level", level, 3'b001);
        check("press_pon", pulse_on, 3'b001);
        check("press_poff", pulse_off, 3'b000);
        check("al_press_level", level_al, 3'b001);
        check("al_press_pon", pulse_on_al, 3'b001);
        @(negedge clk);
        check("press_pon_clear", pulse_on, 3'b000);
        check("press_level_hold", level, 3'b001);
        check("al_pon_clear", pulse_on_al, 3'b000);

        // Release ch0.
        din    = 3'b000;
        din_al = 3'b111;
        tick_step();
        tick_step();
        check("rel_t2_level", level, 3'b001);
        tick_step();
        check("rel_level", level, 3'b000);
        check("rel_poff", pulse_off, 3'b001);
        check("rel_pon", pulse_on, 3'b000);
        check("al_rel_poff", pulse_off_al, 3'b001);
        @(negedge clk);
        check("rel_poff_clear", pulse_off, 3'b000);

        // Bounce on ch1: high 2 ticks, low 1 tick, then held high.
        din = 3'b010;
        tick_step();
        tick_step();
        check("bnc_t2_pon", pulse_on, 3'b000);
        din = 3'b000;
        tick_step();
        check("bnc_low_pon", pulse_on, 3'b000);
        check("bnc_low_level", level, 3'b000);
        din = 3'b010;
        tick_step();
        check("bnc_h1_pon", pulse_on, 3'b000);
        tick_step();
        check("bnc_h2_pon", pulse_on, 3'b000);
        check("bnc_h2_level", level, 3'b000);
        tick_step();
        check("bnc_level", level, 3'b010);
        check("bnc_pon", pulse_on, 3'b010);
        @(negedge clk);
        check("bnc_pon_clear", pulse_on, 3'b000);

        // Bring ch1 back down, then raise ch1 and ch2 together.
        din = 3'b000;
        tick_step();
        tick_step();
        tick_step();
        check("bnc_rel_poff", pulse_off, 3'b010);
        din = 3'b110;
        tick_step();
        tick_step();
        check("sim_t2_pon", pulse_on, 3'b000);
        tick_step();
        check("sim_pon", pulse_on, 3'b110);
        check("sim_level", level, 3'b110);
        @(negedge clk);
        check("sim_pon_clear", pulse_on, 3'b000);

        // Reset mid-debounce: ch2 stays high, ch1 drops (its partial count is discarded).
        din = 3'b100;
        tick_step();
        tick_step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_level", level, 3'b000);
        check("mid_rst_pon", pulse_on, 3'b000);
        check("mid_rst_poff", pulse_off, 3'b000);
        check("mid_rst_tick", {2'b00, tick}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        tick_step();
        check("post_t1_level", level, 3'b000);
        tick_step();
        check("post_t2_pon", pulse_on, 3'b000);
        check("post_t2_al_pon", pulse_on_al, 3'b000);
        tick_step();
        check("post_t3_pon", pulse_on, 3'b100);
        check("post_t3_level", level, 3'b100);
        check("post_t3_poff", pulse_off, 3'b000);
        check("post_al_level", level_al, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
